// File: rtl/llc_req_decoder.sv
// rtl/llc_req_decoder.sv - trace command decoder feeding a small request FIFO toward the cache stage
// Define LLC_REQ_STATS_EN to add the saturating CPU read/write request counters.
module llc_req_decoder #(
  parameter int ADDR_SIZE   = 32,
  parameter int OFFSET_SIZE = 6,
  parameter int INDEX_SIZE  = 14,
  parameter int TAG_SIZE    = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_cmd,
  input  logic [ADDR_SIZE-1:0]          in_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    out_op,
  output logic [TAG_SIZE-1:0]           out_tag,
  output logic [INDEX_SIZE-1:0]         out_index,
  output logic [OFFSET_SIZE-1:0]        out_offset,
  output logic                          illegal_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef LLC_REQ_STATS_EN
  ,
  output logic [31:0]                   stat_reads,
  output logic [31:0]                   stat_writes
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 + TAG_SIZE + INDEX_SIZE + OFFSET_SIZE;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] CMD_CLR = 4'd8;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] new_ent;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       dec_op;
  logic             dec_legal;
  logic             accept, push, pop, bypass;

  always_comb begin
    dec_op    = 3'd0;
    dec_legal = 1'b1;
    case (in_cmd)
      4'd0, 4'd2: dec_op = 3'd0;
      4'd1:       dec_op = 3'd1;
      4'd3:       dec_op = 3'd2;
      4'd4:       dec_op = 3'd3;
      4'd5:       dec_op = 3'd4;
      4'd6:       dec_op = 3'd5;
      4'd8:       dec_op = 3'd6;
      4'd9:       dec_op = 3'd7;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign new_ent = {dec_op,
                    in_addr[ADDR_SIZE-1 -: TAG_SIZE],
                    in_addr[OFFSET_SIZE +: INDEX_SIZE],
                    in_addr[OFFSET_SIZE-1:0]};

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && dec_legal;
  assign pop       = out_valid && out_ready;
  assign illegal_d = accept && !dec_legal;

  // The head is registered; when the surviving buffer would be empty, the incoming entry bypasses storage.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    bypass = pop ? (count_q == CNT_W'(1)) : (count_q == '0);
    head_d = head_q;
    if (count_d != '0) begin
      head_d = bypass ? new_ent : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_ent;
    end
  end

  assign out_op      = head_q[ENT_W-1 -: 3];
  assign out_tag     = head_q[INDEX_SIZE+OFFSET_SIZE +: TAG_SIZE];
  assign out_index   = head_q[OFFSET_SIZE +: INDEX_SIZE];
  assign out_offset  = head_q[OFFSET_SIZE-1:0];
  assign illegal_cmd = illegal_q;
  assign count       = count_q;

`ifdef LLC_REQ_STATS_EN
  logic [31:0] reads_q, reads_d;
  logic [31:0] writes_q, writes_d;

  // CLR wins over counting; it is itself a legal op so it is still buffered.
  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    if (accept && in_cmd == CMD_CLR) begin
      reads_d  = '0;
      writes_d = '0;
    end else if (push && dec_op == 3'd0 && reads_q != '1) begin
      reads_d = reads_q + 32'd1;
    end else if (push && dec_op == 3'd1 && writes_q != '1) begin
      writes_d = writes_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
`endif

endmodule

// File: tb/tb_llc_req_decoder.sv
// tb/tb_llc_req_decoder.sv - self-checking bench for llc_req_decoder (stats checks under LLC_REQ_STATS_EN)
module tb_llc_req_decoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = 4'd0;
  logic [31:0] in_addr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_op;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic        illegal_cmd;
  logic [2:0]  count;
`ifdef LLC_REQ_STATS_EN
  logic [31:0] stat_reads, stat_writes;
`endif

  llc_req_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .illegal_cmd(illegal_cmd), .count(count)
`ifdef LLC_REQ_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct { int op; int tag; int idx; int off; } ent_t;
  ent_t   mq[$];
  ent_t   m_last;
  bit     m_ill;
  longint m_reads, m_writes;
  int     op_tab[16] = '{0, 1, 0, 2, 3, 4, 5, -1, 6, 7, -1, -1, -1, -1, -1, -1};

  // Reference model: queue of decoded requests, updated per clock from the handshake rules.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_last   = '{0, 0, 0, 0};
      m_ill    = 1'b0;
      m_reads  = 0;
      m_writes = 0;
    end else begin
      bit acc, pp;
      int op;
      acc   = in_valid && (mq.size() < DEPTH);
      pp    = out_ready && (mq.size() > 0);
      op    = op_tab[in_cmd];
      m_ill = acc && (op < 0);
      if (pp) void'(mq.pop_front());
      if (acc && op >= 0)
        mq.push_back('{op, int'(in_addr >> 20), int'((in_addr >> 6) % 16384), int'(in_addr % 64)});
      if (acc && in_cmd == 4'd8) begin
        m_reads  = 0;
        m_writes = 0;
      end else if (acc && op == 0 && m_reads < 64'hFFFF_FFFF) begin
        m_reads++;
      end else if (acc && op == 1 && m_writes < 64'hFFFF_FFFF) begin
        m_writes++;
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("in_ready",  in_ready,  mq.size() < DEPTH);
      check("out_valid", out_valid, mq.size() > 0);
      check("count",     count,     mq.size());
      check("illegal",   illegal_cmd, m_ill);
      check("out_op",    out_op,     m_last.op);
      check("out_tag",   out_tag,    m_last.tag);
      check("out_index", out_index,  m_last.idx);
      check("out_off",   out_offset, m_last.off);
`ifdef LLC_REQ_STATS_EN
      check("stat_reads",  stat_reads,  m_reads);
      check("stat_writes", stat_writes, m_writes);
`endif
    end
  end

  task automatic cyc(input bit v, input logic [3:0] c, input logic [31:0] a, input bit r);
    in_valid  = v;
    in_cmd    = c;
    in_addr   = a;
    out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check("rst count", count, 0);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst illegal", illegal_cmd, 0);
    check("rst fields", {out_op, out_tag, out_index, out_offset}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    cyc(1, 4'd0, 32'h1234_5678, 1);
    check("lat1 valid", out_valid, 1);
    check("lat1 op", out_op, 0);
    check("lat1 tag", out_tag, 12'h123);
    check("lat1 index", out_index, 14'h1159);
    check("lat1 offset", out_offset, 6'h38);
    cyc(0, 4'd0, 32'd0, 1);
    check("drained valid", out_valid, 0);
    check("held tag", out_tag, 12'h123);

    cyc(1, 4'd7, 32'hDEAD_BEEF, 1);
    check("ill7 pulse", illegal_cmd, 1);
    check("ill7 count", count, 0);
    check("ill7 valid", out_valid, 0);
    cyc(0, 4'd0, 32'd0, 1);
    check("ill7 end", illegal_cmd, 0);
    cyc(1, 4'd12, 32'hCAFE_F00D, 1);
    check("ill12 pulse", illegal_cmd, 1);
    cyc(0, 4'd0, 32'd0, 1);
    check("ill12 end", illegal_cmd, 0);
    check("ill12 count", count, 0);

    cyc(1, 4'd1, 32'h0000_1040, 0);
    cyc(1, 4'd3, 32'h0010_2080, 0);
    cyc(1, 4'd4, 32'h0020_30C0, 0);
    cyc(1, 4'd5, 32'h0030_4100, 0);
    check("full count", count, 4);
    check("full in_ready", in_ready, 0);
    check("full head op", out_op, 1);
    cyc(1, 4'd6, 32'h0040_5140, 0);
    check("5th held count", count, 4);
    cyc(1, 4'd6, 32'h0040_5140, 1);
    check("pop only count", count, 3);
    check("pop next op", out_op, 2);
    cyc(1, 4'd6, 32'h0040_5140, 0);
    check("5th accepted", count, 4);
    cyc(0, 4'd0, 32'd0, 1);
    check("order op3", out_op, 3);
    cyc(0, 4'd0, 32'd0, 1);
    check("order op4", out_op, 4);
    cyc(0, 4'd0, 32'd0, 1);
    check("order op5", out_op, 5);
    check("order tag5", out_tag, 12'h004);
    cyc(0, 4'd0, 32'd0, 1);
    check("order empty", out_valid, 0);

    cyc(1, 4'd9, 32'h1111_1111, 0);
    cyc(1, 4'd9, 32'h2222_2222, 0);
    cyc(1, 4'd9, 32'h3333_3333, 0);
    check("pre-reset count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async count", count, 0);
    check("async out_valid", out_valid, 0);
    check("async in_ready", in_ready, 1);
    check("async op", out_op, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("no push in reset", count, 0);

    for (int i = 0; i < 16; i++) begin
      a = 32'h9E37_79B9 * (i + 1);
      cyc(1, 4'(i), a, (i % 3) != 0);
    end
    repeat (DEPTH + 1) cyc(0, 4'd0, 32'd0, 1);

`ifdef LLC_REQ_STATS_EN
    cyc(1, 4'd0, 32'h0000_0040, 1);
    cyc(1, 4'd0, 32'h0000_0080, 1);
    cyc(1, 4'd0, 32'h0000_00C0, 1);
    cyc(1, 4'd1, 32'h0000_0100, 1);
    cyc(1, 4'd1, 32'h0000_0140, 1);
    check("stats reads", stat_reads, 3);
    check("stats writes", stat_writes, 2);
    cyc(1, 4'd8, 32'h0000_0180, 1);
    check("clr reads", stat_reads, 0);
    check("clr writes", stat_writes, 0);
    cyc(0, 4'd0, 32'd0, 1);
`endif

    cyc(0, 4'd0, 32'd0, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
